// File: rtl/lut_neuron_loader_if.sv
// lut_neuron_loader_if: config stream, status and lookup signals of the LUT neuron loader.
//   master : drives cfg_start/cfg_valid/cfg_data/cfg_last and in_valid/in_data
//   slave  : drives cfg_ready, load_done, load_err, out_valid, out_data
//   neuron n address = in_data[n*IN_BITS +: IN_BITS], result = out_data[n*OUT_BITS +: OUT_BITS]
interface lut_neuron_loader_if #(
  parameter int IN_BITS     = 6,
  parameter int OUT_BITS    = 1,
  parameter int NUM_NEURONS = 8
);
  logic                            cfg_start;
  logic                            cfg_valid;
  logic                            cfg_ready;
  logic [OUT_BITS-1:0]             cfg_data;
  logic                            cfg_last;
  logic                            load_done;
  logic                            load_err;
  logic                            in_valid;
  logic [NUM_NEURONS*IN_BITS-1:0]  in_data;
  logic                            out_valid;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data;

  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, in_data,
    input  cfg_ready, load_done, load_err, out_valid, out_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, cfg_last, in_valid, in_data,
    output cfg_ready, load_done, load_err, out_valid, out_data
  );
endinterface

// File: rtl/lut_neuron_loader.sv
// lut_neuron_loader: runtime-loadable bank of LUT neurons.
//   Truth-table entries arrive on a valid/ready stream (neuron 0 entries 0..2**IN_BITS-1,
//   then neuron 1, ...) and are written into per-neuron distributed-RAM tables. Once a load
//   completes with cfg_last on the final entry, all neurons answer registered lookups in
//   parallel with 1-cycle latency.
// Ports:
//   clk, rst_n : single clock, synchronous active-low reset
//   bus        : lut_neuron_loader_if.slave (config stream, load status, lookup path)
// Optional feature, macro LUT_READBACK_EN:
//   rb_neuron/rb_addr in, rb_data out: registered table readback, any state, reset 0.

// One neuron: 2**IN_BITS x OUT_BITS table, single write port, registered lookup port.
module lut_neuron_lane #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [IN_BITS-1:0]  waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic                re,
  input  logic [IN_BITS-1:0]  raddr,
  output logic [OUT_BITS-1:0] rdata
`ifdef LUT_READBACK_EN
  ,
  input  logic [IN_BITS-1:0]  peek_addr,
  output logic [OUT_BITS-1:0] peek_data
`endif
);
  logic [OUT_BITS-1:0] mem [2**IN_BITS];

  // table contents are deliberately not reset (distributed RAM)
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // result holds its last value when no lookup fires
  always_ff @(posedge clk)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];

`ifdef LUT_READBACK_EN
  assign peek_data = mem[peek_addr];
`endif
endmodule

module lut_neuron_loader #(
  parameter int IN_BITS     = 6,
  parameter int OUT_BITS    = 1,
  parameter int NUM_NEURONS = 8
) (
  input logic                clk,
  input logic                rst_n,
  lut_neuron_loader_if.slave bus
`ifdef LUT_READBACK_EN
  ,
  input  logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] rb_neuron,
  input  logic [IN_BITS-1:0]  rb_addr,
  output logic [OUT_BITS-1:0] rb_data
`endif
);
  localparam int NW     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int STAGES = 1;
  localparam logic [IN_BITS-1:0] ENTRY_MAX  = '1;
  localparam logic [NW-1:0]      NEURON_MAX = NW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_ACTIVE, S_ERROR} state_t;

  state_t                               state, state_nxt;
  logic [IN_BITS-1:0]                   entry_cnt;
  logic [NW-1:0]                        neuron_cnt;
  logic                                 xfer, at_final, lk_fire;
  logic [STAGES:0]                      vld_pipe;
  logic [NUM_NEURONS-1:0][OUT_BITS-1:0] lane_q;

  // cfg_start wins over everything: it suppresses the write and the lookup of its cycle
  assign xfer     = (state == S_LOAD) & bus.cfg_valid & ~bus.cfg_start;
  assign at_final = (neuron_cnt == NEURON_MAX) & (entry_cnt == ENTRY_MAX);
  assign lk_fire  = (state == S_ACTIVE) & bus.in_valid & ~bus.cfg_start;

  always_ff @(posedge clk)
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_nxt;

  always_comb begin
    state_nxt     = state;
    bus.cfg_ready = 1'b0;
    bus.load_err  = 1'b0;
    case (state)
      S_LOAD: begin
        bus.cfg_ready = 1'b1;
        if (xfer) begin
          if (at_final)          state_nxt = bus.cfg_last ? S_ACTIVE : S_ERROR;
          else if (bus.cfg_last) state_nxt = S_ERROR;
        end
      end
      S_ERROR: bus.load_err = 1'b1;
      default: ;
    endcase
    if (bus.cfg_start) state_nxt = S_LOAD;
  end

  always_ff @(posedge clk)
    if (!rst_n || bus.cfg_start) begin
      entry_cnt  <= '0;
      neuron_cnt <= '0;
    end else if (xfer) begin
      entry_cnt <= entry_cnt + 1'b1;
      if (entry_cnt == ENTRY_MAX) neuron_cnt <= neuron_cnt + 1'b1;
    end

  always_ff @(posedge clk)
    if (!rst_n) bus.load_done <= 1'b0;
    else        bus.load_done <= xfer & at_final & bus.cfg_last;

  assign vld_pipe[0] = lk_fire;
  always_ff @(posedge clk)
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  assign bus.out_valid = vld_pipe[STAGES];

`ifdef LUT_READBACK_EN
  logic [NUM_NEURONS-1:0][OUT_BITS-1:0] peek_q;
`endif

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_lane
    lut_neuron_lane #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (xfer & (neuron_cnt == NW'(n))),
      .waddr     (entry_cnt),
      .wdata     (bus.cfg_data),
      .re        (lk_fire),
      .raddr     (bus.in_data[n*IN_BITS +: IN_BITS]),
      .rdata     (lane_q[n])
`ifdef LUT_READBACK_EN
      ,
      .peek_addr (rb_addr),
      .peek_data (peek_q[n])
`endif
    );
  end

  assign bus.out_data = lane_q;

`ifdef LUT_READBACK_EN
  // out-of-range neuron indices read as 0
  always_ff @(posedge clk)
    if (!rst_n)                        rb_data <= '0;
    else if (rb_neuron <= NEURON_MAX)  rb_data <= peek_q[rb_neuron];
    else                               rb_data <= '0;
`endif
endmodule

// File: tb/tb_lut_neuron_loader.sv
module tb_lut_neuron_loader;
  localparam int IB = 6, OB = 1, NN = 2, DEPTH = 64, TOTAL = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lut_neuron_loader_if #(.IN_BITS(IB), .OUT_BITS(OB), .NUM_NEURONS(NN)) bus ();

`ifdef LUT_READBACK_EN
  logic          rb_neuron = 1'b0;
  logic [IB-1:0] rb_addr = '0;
  logic [OB-1:0] rb_data;
`endif

  lut_neuron_loader #(.IN_BITS(IB), .OUT_BITS(OB), .NUM_NEURONS(NN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LUT_READBACK_EN
    ,
    .rb_neuron (rb_neuron),
    .rb_addr   (rb_addr),
    .rb_data   (rb_data)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: stage = table being streamed, live = tables after the last good load.
  bit stage [NN][DEPTH];
  bit live  [NN][DEPTH];

  function automatic logic [1:0] model_out(input logic [5:0] a0, input logic [5:0] a1);
    return {live[1][a1], live[0][a0]};
  endfunction

  function automatic void fill_pattern();
    for (int a = 0; a < DEPTH; a++) begin
      stage[0][a] = a[0] ^ a[5];
      stage[1][a] = 1'b1;
    end
  endfunction

  function automatic void fill_random();
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < DEPTH; a++) stage[n][a] = 1'($urandom);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.cfg_last  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
  endtask

  task automatic pulse_start();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  // One entry of the stream (index i in write order); optional random idle cycles with junk.
  task automatic send(input int i, input bit last, input bit gaps);
    if (gaps)
      for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 1'($urandom);
        bus.cfg_last  = 1'($urandom);
        tick();
      end
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = stage[i / DEPTH][i % DEPTH];
    bus.cfg_last  = last;
    tick();
    bus.cfg_valid = 1'b0;
    bus.cfg_last  = 1'b0;
  endtask

  task automatic stream(input int count, input int last_idx, input bit gaps);
    for (int i = 0; i < count; i++) send(i, i == last_idx, gaps);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_err++; $display("FAIL reset_cfg_ready got %b want 0", bus.cfg_ready); end
    n_cmp++; if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL reset_load_done got %b want 0", bus.load_done); end
    n_cmp++; if (bus.load_err !== 1'b0)  begin n_err++; $display("FAIL reset_load_err got %b want 0", bus.load_err); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 2'b00) begin n_err++; $display("FAIL reset_out_data got %b want 00", bus.out_data); end
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 12'h041;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL empty_out_valid got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_err++; $display("FAIL empty_cfg_ready got %b want 0", bus.cfg_ready); end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_load();
    logic [1:0] exp;
    fill_pattern();
    pulse_start();
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL load_cfg_ready got %b want 1", bus.cfg_ready); end
    stream(TOTAL - 1, -1, 1'b0);
    n_cmp++; if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL load_done_early got %b want 0", bus.load_done); end
    send(TOTAL - 1, 1'b1, 1'b0);
    live = stage;
    n_cmp++; if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL load_done_pulse got %b want 1", bus.load_done); end
    n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_err++; $display("FAIL active_cfg_ready got %b want 0", bus.cfg_ready); end
    tick();
    n_cmp++; if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL load_done_width got %b want 0", bus.load_done); end
    // neuron 1 at address 5, neuron 0 at address 33 (bits 0 and 5 both set -> entry 0)
    bus.in_valid = 1'b1;
    bus.in_data  = {6'd5, 6'd33};
    tick();
    bus.in_valid = 1'b0;
    exp = model_out(6'd33, 6'd5);
    n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b1, exp})
      begin n_err++; $display("FAIL first_lookup got v=%b d=%b want v=1 d=%b", bus.out_valid, bus.out_data, exp); end
    tick();
    n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b0, exp})
      begin n_err++; $display("FAIL lookup_hold got v=%b d=%b want v=0 d=%b", bus.out_valid, bus.out_data, exp); end
  endtask

  task automatic test_gap_load_sweep();
    logic [5:0] a0, a1;
    logic [1:0] exp;
    fill_pattern();
    pulse_start();
    stream(TOTAL, TOTAL - 1, 1'b1);
    live = stage;
    n_cmp++; if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL gap_load_done got %b want 1", bus.load_done); end
    for (int k = 0; k < DEPTH * DEPTH; k++) begin
      a0 = 6'(k % DEPTH);
      a1 = 6'(k / DEPTH);
      bus.in_valid = 1'b1;
      bus.in_data  = {a1, a0};
      tick();
      exp = model_out(a0, a1);
      n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b1, exp})
        begin n_err++; $display("FAIL sweep a1=%0d a0=%0d got v=%b d=%b want v=1 d=%b", a1, a0, bus.out_valid, bus.out_data, exp); end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random_table();
    logic [5:0] a0, a1;
    logic [1:0] exp_d;
    logic       exp_v;
    fill_random();
    pulse_start();
    stream(TOTAL, TOTAL - 1, 1'b1);
    live = stage;
    n_cmp++; if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL rand_load_done got %b want 1", bus.load_done); end
    exp_d = bus.out_data;
    for (int k = 0; k < 300; k++) begin
      a0 = 6'($urandom);
      a1 = 6'($urandom);
      bus.in_valid  = 1'($urandom);
      bus.in_data   = {a1, a0};
      // config traffic outside LOAD must leave the tables alone
      bus.cfg_valid = 1'($urandom);
      bus.cfg_data  = 1'($urandom);
      tick();
      exp_v = bus.in_valid;
      if (exp_v) exp_d = model_out(a0, a1);
      n_cmp++; if ({bus.out_valid, bus.out_data} !== {exp_v, exp_d})
        begin n_err++; $display("FAIL rand_lookup k=%0d got v=%b d=%b want v=%b d=%b", k, bus.out_valid, bus.out_data, exp_v, exp_d); end
    end
    idle();
    tick();
  endtask

  task automatic test_early_last();
    logic [5:0] a0, a1;
    logic [1:0] exp;
    fill_random();
    pulse_start();
    stream(61, 60, 1'b0);
    n_cmp++; if (bus.load_err !== 1'b1)  begin n_err++; $display("FAIL early_last_err got %b want 1", bus.load_err); end
    n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_err++; $display("FAIL early_last_ready got %b want 0", bus.cfg_ready); end
    n_cmp++; if (bus.load_done !== 1'b0) begin n_err++; $display("FAIL early_last_done got %b want 0", bus.load_done); end
    bus.in_valid  = 1'b1;
    bus.in_data   = 12'($urandom);
    bus.cfg_valid = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL error_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.load_err !== 1'b1)  begin n_err++; $display("FAIL error_sticky got %b want 1", bus.load_err); end
    idle();
    fill_random();
    pulse_start();
    n_cmp++; if (bus.load_err !== 1'b0) begin n_err++; $display("FAIL restart_err got %b want 0", bus.load_err); end
    stream(TOTAL, TOTAL - 1, 1'b0);
    live = stage;
    n_cmp++; if ({bus.load_done, bus.load_err} !== 2'b10)
      begin n_err++; $display("FAIL recover_done got done=%b err=%b want done=1 err=0", bus.load_done, bus.load_err); end
    for (int k = 0; k < 20; k++) begin
      a0 = 6'($urandom);
      a1 = 6'($urandom);
      bus.in_valid = 1'b1;
      bus.in_data  = {a1, a0};
      tick();
      exp = model_out(a0, a1);
      n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b1, exp})
        begin n_err++; $display("FAIL recover_lookup got v=%b d=%b want v=1 d=%b", bus.out_valid, bus.out_data, exp); end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_missing_last_and_abort();
    logic [5:0] a;
    logic [1:0] exp;
    fill_random();
    pulse_start();
    stream(TOTAL, -1, 1'b0);
    n_cmp++; if ({bus.load_err, bus.load_done} !== 2'b10)
      begin n_err++; $display("FAIL missing_last got err=%b done=%b want err=1 done=0", bus.load_err, bus.load_done); end
    // aborted load with different data, then a full reload from entry 0
    fill_random();
    pulse_start();
    stream(70, -1, 1'b0);
    fill_random();
    pulse_start();
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b want 1", bus.cfg_ready); end
    stream(TOTAL - 1, -1, 1'b0);
    n_cmp++; if ({bus.cfg_ready, bus.load_done, bus.load_err} !== 3'b100)
      begin n_err++; $display("FAIL abort_127 got ready=%b done=%b err=%b want 1 0 0", bus.cfg_ready, bus.load_done, bus.load_err); end
    send(TOTAL - 1, 1'b1, 1'b0);
    live = stage;
    n_cmp++; if (bus.load_done !== 1'b1) begin n_err++; $display("FAIL abort_128_done got %b want 1", bus.load_done); end
    for (int k = 0; k < DEPTH; k++) begin
      a = 6'(k);
      bus.in_valid = 1'b1;
      bus.in_data  = {a, a};
      tick();
      exp = model_out(a, a);
      n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b1, exp})
        begin n_err++; $display("FAIL reload_lookup a=%0d got v=%b d=%b want v=1 d=%b", a, bus.out_valid, bus.out_data, exp); end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] a0, a1;
    logic [1:0] held;
    a0 = '0;
    a1 = '0;
    // pick addresses that give a nonzero result so the reset clear is visible
    for (int a = 0; a < DEPTH; a++) begin
      if (live[0][a]) a0 = 6'(a);
      if (live[1][a]) a1 = 6'(a);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = {a1, a0};
    tick();
    held = model_out(a0, a1);
    bus.in_data   = {~a1, ~a0};
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    bus.in_valid  = 1'b0;
    n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b0, held})
      begin n_err++; $display("FAIL start_drops_lookup got v=%b d=%b want v=0 d=%b", bus.out_valid, bus.out_data, held); end
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL start_to_load got %b want 1", bus.cfg_ready); end
    stream(30, -1, 1'b0);
    rst_n = 1'b0;
    tick();
    n_cmp++; if ({bus.cfg_ready, bus.load_done, bus.load_err, bus.out_valid, bus.out_data} !== 6'b0)
      begin n_err++; $display("FAIL midload_reset got ready=%b done=%b err=%b v=%b d=%b want all 0",
        bus.cfg_ready, bus.load_done, bus.load_err, bus.out_valid, bus.out_data); end
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    tick(); tick();
    n_cmp++; if ({bus.out_valid, bus.cfg_ready} !== 2'b00)
      begin n_err++; $display("FAIL post_reset_empty got v=%b ready=%b want 0 0", bus.out_valid, bus.cfg_ready); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load();
    test_gap_load_sweep();
    test_random_table();
    test_early_last();
    test_missing_last_and_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached after %0d compares", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
